mmio_led_ctrl: RTL and testbench
================================

// Module: mmio_led_ctrl
// PURPOSE
//  MMIO-mapped LED controller for the CPU's byte-wide store bus; parametrised successor of the single
//  fixed LED register. Four write registers select static, blink, PWM-dim or chase modes. Output
//  polarity is selectable. A registered readback port returns register contents and live LED state.
//  Sits between the core's mmio_out bus and the board LED pins.
// PARAMETERS
//  NUM_LEDS       6          LED count, 1..8; uses data bits [NUM_LEDS-1:0]
//  BASE_ADDR      16'hf000   address of register 0; registers at BASE_ADDR+0..+4
//  RESET_PATTERN  'b101010   value register reset (NUM_LEDS wide)
//  PRESCALE       27000      clocks per timebase tick, >=1
//  PWM_BITS       8          PWM counter width, 1..8
//  ACTIVE_LOW     0          1: pins driven inverted (led = ~logical)
// PORTS
//  clock          in   1         system clock
//  reset          in   1         synchronous, active-high
//  mmio_out_addr  in   16        store address; a store occurs every cycle it matches a register
//  mmio_out       in   8         store data
//  mmio_in_addr   in   16        readback address
//  mmio_in        out  8         readback data, registered
//  led            out  NUM_LEDS  LED pins, registered
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high. Reset dominates any same-cycle store.
//  Registers and reset values:
//   +0 VALUE  [NUM_LEDS-1:0]  reset RESET_PATTERN
//   +1 MODE   [1:0], 0 static, 1 blink, 2 pwm, 3 chase; reset 0. Upper data bits ignored.
//   +2 DUTY   [PWM_BITS-1:0]  reset all-ones
//   +3 PERIOD [7:0]           reset 8'd1. Counted in ticks.
//   +4 STATUS                 read-only; stores ignored
//  Reset also clears prescaler, period_cnt, pwm_cnt, phase=0, and sets pattern=RESET_PATTERN.
//  After reset: led = RESET_PATTERN (inverted if ACTIVE_LOW); mmio_in = 8'h00.
//  Stores: level-sensitive address match, no strobe. Repeated cycles rewrite the same value.
//   Register updates at the edge ending the store cycle.
//  Timebase:
//   - prescaler counts 0..PRESCALE-1 and pulses tick on wrap.
//   - On tick, if PERIOD==0: period_cnt held 0, no event.
//   - Else if period_cnt+1 >= PERIOD: period_cnt<=0 and an event fires. Otherwise period_cnt++.
//   - Lowering PERIOD below period_cnt means the event fires on the next tick.
//  pwm_cnt: free-running PWM_BITS counter, increments every clock and wraps.
//  Events:
//   - Blink: phase toggles.
//   - Chase: pattern rotates left 1 (MSB->bit0). An all-zero pattern stays 0.
//   - Static/pwm: events have no effect.
//  MODE store: clears prescaler, period_cnt, pwm_cnt and phase, and loads pattern<=VALUE (new VALUE
//   if same cycle N/A). A same-cycle tick or event is discarded; the store wins.
//  VALUE store: also reloads pattern<=new data. Timers are untouched.
//  Logical LED value (lg), evaluated from current registers:
//   static: VALUE
//   blink:  phase ? 0 : VALUE (lit half first)
//   pwm:    (pwm_cnt < DUTY) ? VALUE : 0. DUTY=0 gives always off; max duty is (2^PWM_BITS-1)/2^PWM_BITS.
//   chase:  pattern
//  led <= ACTIVE_LOW ? ~lg : lg, once per clock. A store at edge k is visible on led after edge k+1.
//  Readback: mmio_in <= f(mmio_in_addr) each clock, 1-cycle latency, zero-extended.
//   +0..+3 return the register. +4 returns lg. Any other address returns 8'h00.
//   A store and readback of the same register in the same cycle returns the old value.
// TESTING (PRESCALE=4, NUM_LEDS=6, ACTIVE_LOW=0 unless noted)
//  1 Reset held 3 clk with addr=f000,data=3f:
//    -> led=101010, mmio_in=00.
//    Release, store f000<=0x15 -> led=010101 two edges after the store cycle began.
//  2 Blink, PERIOD=2: store f001<=1.
//    -> led=VALUE for 8 clk, then 0 for 8 clk, repeating.
//    Then store f003<=0 -> blinking freezes in current phase.
//  3 PWM, DUTY=0x40, PWM_BITS=8:
//    -> led=VALUE for 64 of every 256 clk.
//    DUTY=0 -> led=0 constantly. DUTY=ff -> led=0 for 1 clk in 256.
//  4 Chase: VALUE=000001, PERIOD=1, MODE=3.
//    -> led steps 000001,000010,...,100000,000001 every 4 clk.
//    VALUE=0 mid-run -> led=0 and stays 0.
//  5 Mode store coincident with an event edge -> no rotate/toggle; counters restart from 0.
//    Reset asserted mid-chase -> led=101010 next edge, mode static.
//  6 Readback: mmio_in_addr=f003 after PERIOD=7 -> mmio_in=07 next edge.
//    addr f004 in chase -> current pattern. addr f005 or 0000 -> 00.
//    ACTIVE_LOW=1 build: led=~lg while f004 still reads lg.

Source files
------------

// File: rtl/mmio_led_ctrl.sv
// MMIO-mapped LED controller: static, blink, PWM-dim and chase modes driven from a byte-wide store bus,
// with selectable pin polarity and a registered readback port.
module mmio_led_ctrl #(
    parameter int unsigned         NUM_LEDS      = 6,
    parameter logic [15:0]         BASE_ADDR     = 16'hf000,
    parameter logic [NUM_LEDS-1:0] RESET_PATTERN = 'b101010,
    parameter int unsigned         PRESCALE      = 27000,
    parameter int unsigned         PWM_BITS      = 8,
    parameter bit                  ACTIVE_LOW    = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         mmio_out_addr,
    input  logic [7:0]          mmio_out,
    input  logic [15:0]         mmio_in_addr,
    output logic [7:0]          mmio_in,
    output logic [NUM_LEDS-1:0] led
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    localparam int unsigned     PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    localparam logic [15:0] A_VALUE  = BASE_ADDR;
    localparam logic [15:0] A_MODE   = BASE_ADDR + 16'd1;
    localparam logic [15:0] A_DUTY   = BASE_ADDR + 16'd2;
    localparam logic [15:0] A_PERIOD = BASE_ADDR + 16'd3;
    localparam logic [15:0] A_STATUS = BASE_ADDR + 16'd4;

    logic [NUM_LEDS-1:0] r_value;
    mode_t               r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [7:0]          r_period;
    logic [PSC_W-1:0]    r_presc;
    logic [7:0]          r_period_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_phase;
    logic [NUM_LEDS-1:0] r_pattern;
    logic [NUM_LEDS-1:0] r_led;
    logic [7:0]          r_rd;

    logic                w_wr_value;
    logic                w_wr_mode;
    logic                w_wr_duty;
    logic                w_wr_period;
    logic                w_tick;
    logic                w_period_hit;
    logic                w_event;
    logic [NUM_LEDS-1:0] w_rot;
    logic [NUM_LEDS-1:0] w_lg;
    logic [7:0]          w_rd;

    assign w_wr_value  = (mmio_out_addr == A_VALUE);
    assign w_wr_mode   = (mmio_out_addr == A_MODE);
    assign w_wr_duty   = (mmio_out_addr == A_DUTY);
    assign w_wr_period = (mmio_out_addr == A_PERIOD);

    // Compare in 9 bits so a lowered PERIOD below period_cnt still fires on the next tick.
    assign w_tick       = (r_presc == PSC_LAST);
    assign w_period_hit = ({1'b0, r_period_cnt} + 9'd1) >= {1'b0, r_period};
    assign w_event      = w_tick && (r_period != 8'd0) && w_period_hit;

    // Left rotate; degenerates to identity when NUM_LEDS is 1.
    assign w_rot = (r_pattern << 1) | (r_pattern >> (NUM_LEDS - 1));

    always_comb begin
        w_lg = '0;
        case (r_mode)
            MODE_STATIC: w_lg = r_value;
            MODE_BLINK:  w_lg = r_phase ? '0 : r_value;
            MODE_PWM:    w_lg = (r_pwm_cnt < r_duty) ? r_value : '0;
            MODE_CHASE:  w_lg = r_pattern;
            default:     w_lg = '0;
        endcase
    end

    always_comb begin
        w_rd = '0;
        if (mmio_in_addr == A_VALUE)
            w_rd[NUM_LEDS-1:0] = r_value;
        else if (mmio_in_addr == A_MODE)
            w_rd[1:0] = r_mode;
        else if (mmio_in_addr == A_DUTY)
            w_rd[PWM_BITS-1:0] = r_duty;
        else if (mmio_in_addr == A_PERIOD)
            w_rd = r_period;
        else if (mmio_in_addr == A_STATUS)
            w_rd[NUM_LEDS-1:0] = w_lg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value      <= RESET_PATTERN;
            r_mode       <= MODE_STATIC;
            r_duty       <= '1;
            r_period     <= 8'd1;
            r_presc      <= '0;
            r_period_cnt <= '0;
            r_pwm_cnt    <= '0;
            r_phase      <= 1'b0;
            r_pattern    <= RESET_PATTERN;
            r_led        <= ACTIVE_LOW ? ~RESET_PATTERN : RESET_PATTERN;
            r_rd         <= '0;
        end else begin
            if (w_wr_value)
                r_value <= mmio_out[NUM_LEDS-1:0];
            if (w_wr_duty)
                r_duty <= mmio_out[PWM_BITS-1:0];
            if (w_wr_period)
                r_period <= mmio_out;

            // A MODE store restarts all timers and swallows any same-cycle tick or event.
            if (w_wr_mode) begin
                r_mode       <= mode_t'(mmio_out[1:0]);
                r_presc      <= '0;
                r_period_cnt <= '0;
                r_pwm_cnt    <= '0;
                r_phase      <= 1'b0;
                r_pattern    <= r_value;
            end else begin
                r_presc   <= w_tick ? '0 : r_presc + 1'b1;
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
                if (w_tick) begin
                    if (r_period == 8'd0 || w_period_hit)
                        r_period_cnt <= '0;
                    else
                        r_period_cnt <= r_period_cnt + 8'd1;
                end
                if (w_event && r_mode == MODE_BLINK)
                    r_phase <= ~r_phase;
                if (w_wr_value)
                    r_pattern <= mmio_out[NUM_LEDS-1:0];
                else if (w_event && r_mode == MODE_CHASE)
                    r_pattern <= w_rot;
            end

            r_led <= ACTIVE_LOW ? ~w_lg : w_lg;
            r_rd  <= w_rd;
        end
    end

    assign led     = r_led;
    assign mmio_in = r_rd;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Directed bench for mmio_led_ctrl: register/readback vector table plus blink, PWM, chase,
// mode-store-on-event, mid-run reset and active-low sequences.
module tb_mmio_led_ctrl;

    logic        clock;
    logic        reset;
    logic [15:0] mmio_out_addr;
    logic [7:0]  mmio_out;
    logic [15:0] mmio_in_addr;
    logic [7:0]  mmio_in;
    logic [5:0]  led;
    logic [7:0]  mmio_in_al;
    logic [5:0]  led_al;

    int n_checks = 0;
    int n_err    = 0;

    mmio_led_ctrl #(
        .NUM_LEDS(6), .BASE_ADDR(16'hf000), .RESET_PATTERN(6'b101010),
        .PRESCALE(4), .PWM_BITS(8), .ACTIVE_LOW(1'b0)
    ) dut (
        .clock(clock), .reset(reset),
        .mmio_out_addr(mmio_out_addr), .mmio_out(mmio_out),
        .mmio_in_addr(mmio_in_addr), .mmio_in(mmio_in), .led(led)
    );

    mmio_led_ctrl #(
        .NUM_LEDS(6), .BASE_ADDR(16'hf000), .RESET_PATTERN(6'b101010),
        .PRESCALE(4), .PWM_BITS(8), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clock(clock), .reset(reset),
        .mmio_out_addr(mmio_out_addr), .mmio_out(mmio_out),
        .mmio_in_addr(mmio_in_addr), .mmio_in(mmio_in_al), .led(led_al)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] oaddr;
        logic [7:0]  odata;
        logic [15:0] iaddr;
        logic [5:0]  exp_led;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [15:0] addr, input logic [7:0] data);
        mmio_out_addr = addr;
        mmio_out      = data;
        step();
        mmio_out_addr = 16'h0000;
        mmio_out      = 8'h00;
    endtask

    initial begin
        logic [5:0] exp;
        logic [5:0] inv;

        vecs[0]  = '{16'h0000, 8'h00, 16'hf000, 6'h2a, 8'h2a};
        vecs[1]  = '{16'hf000, 8'h15, 16'hf000, 6'h2a, 8'h2a};
        vecs[2]  = '{16'h0000, 8'h00, 16'hf000, 6'h15, 8'h15};
        vecs[3]  = '{16'hf000, 8'hff, 16'hf001, 6'h15, 8'h00};
        vecs[4]  = '{16'h0000, 8'h00, 16'hf000, 6'h3f, 8'h3f};
        vecs[5]  = '{16'hf002, 8'h40, 16'hf002, 6'h3f, 8'hff};
        vecs[6]  = '{16'hf003, 8'h07, 16'hf002, 6'h3f, 8'h40};
        vecs[7]  = '{16'h0000, 8'h00, 16'hf003, 6'h3f, 8'h07};
        vecs[8]  = '{16'h0000, 8'h00, 16'hf004, 6'h3f, 8'h3f};
        vecs[9]  = '{16'h0000, 8'h00, 16'hf005, 6'h3f, 8'h00};
        vecs[10] = '{16'h0000, 8'h00, 16'h0000, 6'h3f, 8'h00};
        vecs[11] = '{16'hf004, 8'h55, 16'hf004, 6'h3f, 8'h3f};
        vecs[12] = '{16'hf001, 8'h04, 16'hf001, 6'h3f, 8'h00};
        vecs[13] = '{16'h0000, 8'h00, 16'hf001, 6'h3f, 8'h00};
        vecs[14] = '{16'hf003, 8'h01, 16'hf003, 6'h3f, 8'h07};
        vecs[15] = '{16'hf002, 8'hff, 16'hf003, 6'h3f, 8'h01};
        vecs[16] = '{16'h0000, 8'h00, 16'hf002, 6'h3f, 8'hff};

        // Reset held with a coincident VALUE store, which must lose.
        reset         = 1'b1;
        mmio_out_addr = 16'hf000;
        mmio_out      = 8'h3f;
        mmio_in_addr  = 16'hf000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_led", led, 6'h2a);
            check("reset_rd", mmio_in, 8'h00);
            check("reset_led_al", led_al, 6'h15);
        end
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            mmio_out_addr = vecs[i].oaddr;
            mmio_out      = vecs[i].odata;
            mmio_in_addr  = vecs[i].iaddr;
            step();
            inv = ~vecs[i].exp_led;
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
            check($sformatf("vec%0d_rd", i), mmio_in, vecs[i].exp_rd);
            check($sformatf("vec%0d_led_al", i), led_al, inv);
            check($sformatf("vec%0d_rd_al", i), mmio_in_al, vecs[i].exp_rd);
        end
        mmio_out_addr = 16'h0000;
        mmio_out      = 8'h00;
        mmio_in_addr  = 16'h0000;

        // Blink, PERIOD=2: 8 lit, 8 dark; freeze in dark phase with PERIOD=0.
        store(16'hf003, 8'h02);
        store(16'hf001, 8'h01);
        for (int j = 1; j <= 12; j++) begin
            step();
            exp = (((j - 1) / 8) % 2 != 0) ? 6'h00 : 6'h3f;
            check("blink_led", led, exp);
        end
        store(16'hf003, 8'h00);
        for (int j = 0; j < 24; j++) begin
            step();
            check("blink_frozen", led, 6'h00);
        end

        // PWM, DUTY=0x40: lit for 64 of every 256 clocks.
        store(16'hf002, 8'h40);
        store(16'hf001, 8'h02);
        for (int j = 1; j <= 300; j++) begin
            step();
            exp = (((j - 1) % 256) < 64) ? 6'h3f : 6'h00;
            check("pwm40_led", led, exp);
        end
        store(16'hf002, 8'h00);
        for (int j = 0; j < 300; j++) begin
            step();
            check("pwm00_led", led, 6'h00);
        end
        store(16'hf002, 8'hff);
        store(16'hf001, 8'h02);
        for (int j = 1; j <= 300; j++) begin
            step();
            exp = (((j - 1) % 256) < 255) ? 6'h3f : 6'h00;
            check("pwmff_led", led, exp);
        end

        // Chase, PERIOD=1: one step every 4 clocks; STATUS reads the live pattern.
        store(16'hf000, 8'h01);
        store(16'hf003, 8'h01);
        store(16'hf001, 8'h03);
        mmio_in_addr = 16'hf004;
        for (int j = 1; j <= 30; j++) begin
            step();
            exp = 6'h01 << (((j - 1) / 4) % 6);
            check("chase_led", led, exp);
            check("chase_status", mmio_in, {2'b00, exp});
        end
        mmio_in_addr = 16'h0000;
        store(16'hf000, 8'h00);
        for (int j = 0; j < 20; j++) begin
            step();
            check("chase_zero", led, 6'h00);
        end

        // MODE store landing on an event edge: no rotate, timers restart.
        store(16'hf000, 8'h01);
        store(16'hf001, 8'h03);
        repeat (7) step();
        store(16'hf001, 8'h03);
        for (int j = 1; j <= 12; j++) begin
            step();
            exp = 6'h01 << (((j - 1) / 4) % 6);
            check("modeevt_led", led, exp);
        end

        // Reset mid-chase returns to the reset pattern in static mode.
        reset = 1'b1;
        step();
        check("midreset_led", led, 6'h2a);
        reset        = 1'b0;
        mmio_in_addr = 16'hf001;
        step();
        check("midreset_mode", mmio_in, 8'h00);
        for (int j = 0; j < 8; j++) begin
            step();
            check("midreset_static", led, 6'h2a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
